fcvt_pipe: RTL and testbench

Pipelined, parametrised single-precision float ↔ integer converter with RISC-V rounding-mode support and exception flags. It is the successor to the combinational FCVT unit and covers FCVT.W[U].S, FCVT.S.W[U] and, with XLEN=64, FCVT.L[U].S and FCVT.S.L[U]. It sits in the FPU execute stage behind a valid/ready handshake, with 2-cycle latency and one operation accepted per cycle.

---
 rtl/fcvt_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_fcvt_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_pipe.sv
// fcvt_pipe: two-stage float32 <-> integer converter (FCVT.W[U].S, FCVT.S.W[U],
// and the L/LU forms when XLEN=64) with RISC-V rounding modes and fflags.
// XLEN must be 32 or 64.
//
// Handshake: one global advance signal, advance = ready_i | ~valid_o, drives
// ready_o and enables both stage registers together. An input transfers on
// valid_i & ready_o, an output on valid_o & ready_i. While valid_o=1 and
// ready_i=0 nothing moves, so result_o/fflags_o stay stable. Empty slots travel
// as invalid stage entries; a transfer out and a transfer in may share a cycle.
module fcvt_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic            op_signed_i,
    input  logic            conv_type_i,
    input  logic [2:0]      rm_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      fflags_o
);
    // F->I shifter width: XLEN integer bits above 24 fraction bits
    localparam int TW = XLEN + 24;
    // Largest biased exponent whose magnitude stays below 2^XLEN
    localparam logic [7:0] EMAX_IN = 8'(127 + XLEN - 1);
    // 2^(XLEN-1) in the XLEN+1 bit rounded-magnitude domain
    localparam logic [XLEN:0] HALF = {2'b01, {(XLEN-1){1'b0}}};

    // Rounding increment decision from sign, kept LSB, guard and sticky
    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic g, input logic s);
        logic up;
        case (rm)
            3'b001:  up = 1'b0;             // RTZ
            3'b010:  up = sign & (g | s);   // RDN
            3'b011:  up = ~sign & (g | s);  // RUP
            3'b100:  up = g;                // RMM
            default: up = g & (s | lsb);    // RNE and reserved codes
        endcase
        return up;
    endfunction

    logic            w_advance;

    // Stage-1 combinational signals
    logic [7:0]      w_f_exp;
    logic [22:0]     w_f_man;
    logic [23:0]     w_f_sig;
    logic [7:0]      w_f_k;
    logic [TW-1:0]   w_f_shifted;
    logic [XLEN-1:0] w_i_mag;
    logic [XLEN-1:0] w_i_norm;
    logic [7:0]      w_i_lzc;
    logic            w_s1_sign;
    logic [XLEN-1:0] w_s1_mag;
    logic [7:0]      w_s1_exp;
    logic            w_s1_g;
    logic            w_s1_s;
    logic            w_s1_ovf;
    logic            w_s1_nan;
    logic            w_s1_zero;

    // Stage-1 registers
    logic            r_s1_valid;
    logic            r_s1_conv;
    logic            r_s1_signed;
    logic [2:0]      r_s1_rm;
    logic            r_s1_sign;
    logic [XLEN-1:0] r_s1_mag;
    logic [7:0]      r_s1_exp;
    logic            r_s1_g;
    logic            r_s1_s;
    logic            r_s1_ovf;
    logic            r_s1_nan;
    logic            r_s1_zero;

    // Stage-2 combinational signals
    logic            w_up;
    logic            w_inexact;
    logic [XLEN:0]   w_rmag;
    logic [24:0]     w_mant;
    logic [XLEN-1:0] w_sat_pos;
    logic [XLEN-1:0] w_sat_neg;
    logic            w_in_range;
    logic [7:0]      w_exp_out;
    logic [22:0]     w_frac_out;
    logic [XLEN-1:0] w_s2_result;
    logic [4:0]      w_s2_fflags;

    // Output registers
    logic            r_valid_o;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_fflags;

    assign w_advance = ready_i | ~r_valid_o;
    assign ready_o   = w_advance;
    assign valid_o   = r_valid_o;
    assign result_o  = r_result;
    assign fflags_o  = r_fflags;

    // Stage 1: unpack, align float to fixed point or normalise integer, collect GRS
    always_comb begin
        w_f_exp     = a_i[30:23];
        w_f_man     = a_i[22:0];
        w_f_sig     = {(w_f_exp != 8'd0), w_f_man};
        w_f_k       = w_f_exp - 8'd126;
        w_f_shifted = {{XLEN{1'b0}}, w_f_sig} << w_f_k;

        w_i_mag = (op_signed_i && a_i[XLEN-1]) ? -a_i : a_i;
        w_i_lzc = 8'd0;
        for (int i = 0; i < XLEN; i++) begin
            if (w_i_mag[i]) w_i_lzc = 8'(XLEN - 1 - i);
        end
        w_i_norm = w_i_mag << w_i_lzc;

        w_s1_sign = 1'b0;
        w_s1_mag  = '0;
        w_s1_exp  = 8'd0;
        w_s1_g    = 1'b0;
        w_s1_s    = 1'b0;
        w_s1_ovf  = 1'b0;
        w_s1_nan  = 1'b0;
        w_s1_zero = 1'b0;

        if (conv_type_i) begin
            // Int->float: keep 24 significant bits, the rest become guard/sticky
            w_s1_sign = op_signed_i & a_i[XLEN-1];
            w_s1_mag  = {{(XLEN-24){1'b0}}, w_i_norm[XLEN-1 -: 24]};
            w_s1_exp  = 8'(127 + XLEN - 1) - w_i_lzc;
            w_s1_g    = w_i_norm[XLEN-25];
            w_s1_s    = |w_i_norm[XLEN-26:0];
            w_s1_zero = (w_i_mag == '0);
        end else begin
            w_s1_sign = a_i[31];
            if (w_f_exp == 8'hFF) begin
                w_s1_ovf = 1'b1;
                w_s1_nan = (w_f_man != 23'd0);
            end else if (w_f_exp > EMAX_IN) begin
                w_s1_ovf = 1'b1;
            end else if (w_f_exp >= 8'd126) begin
                // Magnitude >= 0.5: the shifter holds integer, guard and sticky
                w_s1_mag = w_f_shifted[TW-1:24];
                w_s1_g   = w_f_shifted[23];
                w_s1_s   = |w_f_shifted[22:0];
            end else begin
                // Below 0.5 (incl. subnormals): only sticky can be set
                w_s1_s = (w_f_exp != 8'd0) || (w_f_man != 23'd0);
            end
        end
    end

    // Stage 2: round, range-check and saturate (F->I) or pack (I->F), form flags
    always_comb begin
        w_up       = round_up(r_s1_rm, r_s1_sign, r_s1_mag[0], r_s1_g, r_s1_s);
        w_inexact  = r_s1_g | r_s1_s;
        w_rmag     = {1'b0, r_s1_mag} + {{XLEN{1'b0}}, w_up};
        w_mant     = {1'b0, r_s1_mag[23:0]} + {24'd0, w_up};
        w_sat_pos  = r_s1_signed ? {1'b0, {(XLEN-1){1'b1}}} : {XLEN{1'b1}};
        w_sat_neg  = r_s1_signed ? {1'b1, {(XLEN-1){1'b0}}} : {XLEN{1'b0}};
        w_in_range = 1'b0;
        w_exp_out  = r_s1_exp + {7'd0, w_mant[24]};
        // A carry-out leaves the fraction all zero, so either slice works there
        w_frac_out = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
        w_s2_result = '0;
        w_s2_fflags = 5'd0;

        if (r_s1_conv) begin
            // NaN-box: bits above 31 read as ones when XLEN=64
            w_s2_result = '1;
            if (r_s1_zero) begin
                w_s2_result[31:0] = 32'd0;
            end else begin
                w_s2_result[31:0] = {r_s1_sign, w_exp_out, w_frac_out};
                w_s2_fflags[0]    = w_inexact;
            end
        end else if (r_s1_nan) begin
            w_s2_result    = w_sat_pos;
            w_s2_fflags[4] = 1'b1;
        end else if (r_s1_ovf) begin
            w_s2_result    = r_s1_sign ? w_sat_neg : w_sat_pos;
            w_s2_fflags[4] = 1'b1;
        end else begin
            if (r_s1_signed) begin
                w_in_range = r_s1_sign ? (w_rmag <= HALF) : (w_rmag < HALF);
            end else begin
                // Negative values are legal unsigned only when they round to 0
                w_in_range = !w_rmag[XLEN] && (!r_s1_sign || (w_rmag == '0));
            end
            if (w_in_range) begin
                w_s2_result    = r_s1_sign ? -w_rmag[XLEN-1:0] : w_rmag[XLEN-1:0];
                w_s2_fflags[0] = w_inexact;
            end else begin
                w_s2_result    = r_s1_sign ? w_sat_neg : w_sat_pos;
                w_s2_fflags[4] = 1'b1;
            end
        end
    end

    // Stage-1 payload: loaded on every advance, meaningful only with r_s1_valid
    always_ff @(posedge clk_i) begin
        if (w_advance) begin
            r_s1_conv   <= conv_type_i;
            r_s1_signed <= op_signed_i;
            r_s1_rm     <= rm_i;
            r_s1_sign   <= w_s1_sign;
            r_s1_mag    <= w_s1_mag;
            r_s1_exp    <= w_s1_exp;
            r_s1_g      <= w_s1_g;
            r_s1_s      <= w_s1_s;
            r_s1_ovf    <= w_s1_ovf;
            r_s1_nan    <= w_s1_nan;
            r_s1_zero   <= w_s1_zero;
        end
    end

    // Slot valids and output registers: cleared by reset, shift together on advance
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_valid_o  <= 1'b0;
            r_result   <= '0;
            r_fflags   <= 5'd0;
        end else if (w_advance) begin
            r_s1_valid <= valid_i;
            r_valid_o  <= r_s1_valid;
            r_result   <= w_s2_result;
            r_fflags   <= w_s2_fflags;
        end
    end

endmodule

// File: tb/tb_fcvt_pipe.sv
// Directed bench for fcvt_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_fcvt_pipe;

    localparam logic [4:0] NV = 5'b10000;
    localparam logic [4:0] NX = 5'b00001;
    localparam logic [4:0] F0 = 5'b00000;

    typedef struct {
        logic [31:0] a;
        logic        sgn;
        logic        conv;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec32_t;

    int n_cmp = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic rst_n;

    logic        v32_i, rdy32_o, sgn32, conv32, v32_o, rdy32_i;
    logic [31:0] a32, res32_o;
    logic [2:0]  rm32;
    logic [4:0]  fl32_o;

    logic        v64_i, rdy64_o, sgn64, conv64, v64_o, rdy64_i;
    logic [63:0] a64, res64_o;
    logic [2:0]  rm64;
    logic [4:0]  fl64_o;

    always #5 clk = ~clk;

    fcvt_pipe #(.XLEN(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v32_i), .ready_o(rdy32_o),
        .a_i(a32), .op_signed_i(sgn32), .conv_type_i(conv32), .rm_i(rm32),
        .valid_o(v32_o), .ready_i(rdy32_i), .result_o(res32_o), .fflags_o(fl32_o)
    );

    fcvt_pipe #(.XLEN(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v64_i), .ready_o(rdy64_o),
        .a_i(a64), .op_signed_i(sgn64), .conv_type_i(conv64), .rm_i(rm64),
        .valid_o(v64_o), .ready_i(rdy64_i), .result_o(res64_o), .fflags_o(fl64_o)
    );

    // Driver: issue one op to the 32-bit DUT and wait (bounded) for its result
    task automatic do_op32(input logic [31:0] a, input logic sgn, input logic conv,
                           input logic [2:0] rm, output logic [31:0] res, output logic [4:0] fl);
        int cnt;
        @(negedge clk);
        a32 = a; sgn32 = sgn; conv32 = conv; rm32 = rm; v32_i = 1'b1; rdy32_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32_i = 1'b0;
        cnt = 0;
        while (!v32_o && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (!v32_o) begin
            n_cmp++; n_fail++;
            $display("FAIL op32_timeout: valid_o got 0 want 1 (a=%h)", a);
        end
        res = res32_o;
        fl = fl32_o;
    endtask

    // Driver: issue one op to the 64-bit DUT and wait (bounded) for its result
    task automatic do_op64(input logic [63:0] a, input logic sgn, input logic conv,
                           input logic [2:0] rm, output logic [63:0] res, output logic [4:0] fl);
        int cnt;
        @(negedge clk);
        a64 = a; sgn64 = sgn; conv64 = conv; rm64 = rm; v64_i = 1'b1; rdy64_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v64_i = 1'b0;
        cnt = 0;
        while (!v64_o && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (!v64_o) begin
            n_cmp++; n_fail++;
            $display("FAIL op64_timeout: valid_o got 0 want 1 (a=%h)", a);
        end
        res = res64_o;
        fl = fl64_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (v32_o !== 1'b0 || rdy32_o !== 1'b1 || res32_o !== 32'd0 || fl32_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset32: got v=%b rdy=%b res=%h fl=%b want v=0 rdy=1 res=0 fl=0",
                     v32_o, rdy32_o, res32_o, fl32_o);
        end
        n_cmp++;
        if (v64_o !== 1'b0 || rdy64_o !== 1'b1 || res64_o !== 64'd0 || fl64_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset64: got v=%b rdy=%b res=%h fl=%b want v=0 rdy=1 res=0 fl=0",
                     v64_o, rdy64_o, res64_o, fl64_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_f2i_round();
        vec32_t t[10];
        logic [31:0] r;
        logic [4:0]  f;
        t[0] = '{32'h40200000, 1'b1, 1'b0, 3'd0, 32'd2,         NX};
        t[1] = '{32'h40200000, 1'b1, 1'b0, 3'd1, 32'd2,         NX};
        t[2] = '{32'h40200000, 1'b1, 1'b0, 3'd2, 32'd2,         NX};
        t[3] = '{32'h40200000, 1'b1, 1'b0, 3'd3, 32'd3,         NX};
        t[4] = '{32'h40200000, 1'b1, 1'b0, 3'd4, 32'd3,         NX};
        t[5] = '{32'h40200000, 1'b1, 1'b0, 3'd7, 32'd2,         NX};
        t[6] = '{32'hC0200000, 1'b1, 1'b0, 3'd2, 32'hFFFFFFFD,  NX};
        t[7] = '{32'h3FC00000, 1'b1, 1'b0, 3'd0, 32'd2,         NX};
        t[8] = '{32'h00000001, 1'b1, 1'b0, 3'd3, 32'd1,         NX};
        t[9] = '{32'h80000000, 1'b0, 1'b0, 3'd0, 32'd0,         F0};
        for (int i = 0; i < 10; i++) begin
            do_op32(t[i].a, t[i].sgn, t[i].conv, t[i].rm, r, f);
            n_cmp++;
            if (r !== t[i].res || f !== t[i].fl) begin
                n_fail++;
                $display("FAIL f2i_round[%0d] a=%h rm=%0d: got %h/%b want %h/%b",
                         i, t[i].a, t[i].rm, r, f, t[i].res, t[i].fl);
            end
        end
    endtask

    task automatic test_f2i_sat();
        vec32_t t[10];
        logic [31:0] r;
        logic [4:0]  f;
        t[0] = '{32'hCF000001, 1'b1, 1'b0, 3'd0, 32'h80000000, NV};
        t[1] = '{32'h7FC00000, 1'b1, 1'b0, 3'd0, 32'h7FFFFFFF, NV};
        t[2] = '{32'hBF800000, 1'b0, 1'b0, 3'd0, 32'h00000000, NV};
        t[3] = '{32'hBF000000, 1'b0, 1'b0, 3'd0, 32'h00000000, NX};
        t[4] = '{32'h4F800000, 1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, NV};
        t[5] = '{32'h4F000000, 1'b1, 1'b0, 3'd0, 32'h7FFFFFFF, NV};
        t[6] = '{32'hFF800000, 1'b1, 1'b0, 3'd0, 32'h80000000, NV};
        t[7] = '{32'h7F800000, 1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, NV};
        t[8] = '{32'h7FC00000, 1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, NV};
        t[9] = '{32'hBF000000, 1'b0, 1'b0, 3'd2, 32'h00000000, NV};
        for (int i = 0; i < 10; i++) begin
            do_op32(t[i].a, t[i].sgn, t[i].conv, t[i].rm, r, f);
            n_cmp++;
            if (r !== t[i].res || f !== t[i].fl) begin
                n_fail++;
                $display("FAIL f2i_sat[%0d] a=%h sgn=%b rm=%0d: got %h/%b want %h/%b",
                         i, t[i].a, t[i].sgn, t[i].rm, r, f, t[i].res, t[i].fl);
            end
        end
    endtask

    task automatic test_i2f();
        vec32_t t[9];
        logic [31:0] r;
        logic [4:0]  f;
        t[0] = '{32'h01000001, 1'b0, 1'b1, 3'd0, 32'h4B800000, NX};
        t[1] = '{32'h01000001, 1'b0, 1'b1, 3'd3, 32'h4B800001, NX};
        t[2] = '{32'hFFFFFFFF, 1'b1, 1'b1, 3'd0, 32'hBF800000, F0};
        t[3] = '{32'h80000000, 1'b1, 1'b1, 3'd0, 32'hCF000000, F0};
        t[4] = '{32'h00000000, 1'b1, 1'b1, 3'd0, 32'h00000000, F0};
        t[5] = '{32'hFFFFFFFF, 1'b0, 1'b1, 3'd0, 32'h4F800000, NX};
        t[6] = '{32'hFFFFFFFF, 1'b0, 1'b1, 3'd1, 32'h4F7FFFFF, NX};
        t[7] = '{32'h00000003, 1'b1, 1'b1, 3'd0, 32'h40400000, F0};
        t[8] = '{32'hFFFFFFFD, 1'b1, 1'b1, 3'd2, 32'hC0400000, F0};
        for (int i = 0; i < 9; i++) begin
            do_op32(t[i].a, t[i].sgn, t[i].conv, t[i].rm, r, f);
            n_cmp++;
            if (r !== t[i].res || f !== t[i].fl) begin
                n_fail++;
                $display("FAIL i2f[%0d] a=%h sgn=%b rm=%0d: got %h/%b want %h/%b",
                         i, t[i].a, t[i].sgn, t[i].rm, r, f, t[i].res, t[i].fl);
            end
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] a_t[5];
        logic        s_t[5];
        logic        c_t[5];
        logic [2:0]  rm_t[5];
        logic [63:0] e_t[5];
        logic [4:0]  f_t[5];
        logic [63:0] r;
        logic [4:0]  f;
        a_t[0] = 64'h8000000000000000; s_t[0] = 1'b0; c_t[0] = 1'b1; rm_t[0] = 3'd0;
        e_t[0] = 64'hFFFFFFFF5F000000; f_t[0] = F0;
        a_t[1] = 64'h000000005F800000; s_t[1] = 1'b0; c_t[1] = 1'b0; rm_t[1] = 3'd0;
        e_t[1] = 64'hFFFFFFFFFFFFFFFF; f_t[1] = NV;
        a_t[2] = 64'h00000000DF000000; s_t[2] = 1'b1; c_t[2] = 1'b0; rm_t[2] = 3'd0;
        e_t[2] = 64'h8000000000000000; f_t[2] = F0;
        a_t[3] = 64'hFFFFFFFFFFFFFFFF; s_t[3] = 1'b0; c_t[3] = 1'b1; rm_t[3] = 3'd0;
        e_t[3] = 64'hFFFFFFFF5F800000; f_t[3] = NX;
        a_t[4] = 64'hDEADBEEF40200000; s_t[4] = 1'b1; c_t[4] = 1'b0; rm_t[4] = 3'd4;
        e_t[4] = 64'd3;                f_t[4] = NX;
        for (int i = 0; i < 5; i++) begin
            do_op64(a_t[i], s_t[i], c_t[i], rm_t[i], r, f);
            n_cmp++;
            if (r !== e_t[i] || f !== f_t[i]) begin
                n_fail++;
                $display("FAIL xlen64[%0d] a=%h: got %h/%b want %h/%b",
                         i, a_t[i], r, f, e_t[i], f_t[i]);
            end
        end
    endtask

    // Streams 16 unsigned int->float ops of 2^k; expected value is 2^k as a float
    task automatic run_stream(input logic random_ready, input string tag);
        logic [31:0] exp_q[$];
        int          acc_q[$];
        int          sent;
        int          got;
        int          cyc;
        int          ac;
        logic        hold;
        logic [31:0] held_res;
        logic [4:0]  held_fl;
        logic [31:0] e;
        sent = 0; got = 0; cyc = 0; hold = 1'b0; held_res = '0; held_fl = '0;
        @(negedge clk);
        while (got < 16 && cyc < 400) begin
            if (hold) begin
                n_cmp++;
                if (v32_o !== 1'b1 || res32_o !== held_res || fl32_o !== held_fl) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold cyc=%0d: got v=%b %h/%b want v=1 %h/%b",
                             tag, cyc, v32_o, res32_o, fl32_o, held_res, held_fl);
                end
            end
            rdy32_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            v32_i   = (sent < 16);
            a32     = 32'd1 << sent;
            sgn32   = 1'b0; conv32 = 1'b1; rm32 = 3'd0;
            #1;
            if (v32_o && rdy32_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra cyc=%0d: got result %h want none", tag, cyc, res32_o);
                end else begin
                    e  = exp_q.pop_front();
                    ac = acc_q.pop_front();
                    if (res32_o !== e || fl32_o !== F0) begin
                        n_fail++;
                        $display("FAIL %s_data[%0d]: got %h/%b want %h/%b",
                                 tag, got, res32_o, fl32_o, e, F0);
                    end
                    if (!random_ready) begin
                        n_cmp++;
                        if (cyc - ac != 2) begin
                            n_fail++;
                            $display("FAIL %s_latency[%0d]: got %0d want 2", tag, got, cyc - ac);
                        end
                    end
                    got++;
                end
            end
            if (v32_i && rdy32_o) begin
                exp_q.push_back({1'b0, 8'(127 + sent), 23'd0});
                acc_q.push_back(cyc);
                sent++;
            end
            hold     = v32_o && !rdy32_i;
            held_res = res32_o;
            held_fl  = fl32_o;
            @(negedge clk);
            cyc++;
        end
        v32_i   = 1'b0;
        rdy32_i = 1'b1;
        n_cmp++;
        if (got != 16) begin
            n_fail++;
            $display("FAIL %s_count: got %0d results want 16", tag, got);
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (v32_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_drain: got valid_o=%b want 0", tag, v32_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_stream(1'b0, "back_to_back");
    endtask

    task automatic test_backpressure();
        run_stream(1'b1, "backpressure");
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [4:0]  f;
        @(negedge clk);
        rdy32_i = 1'b0; v32_i = 1'b1; a32 = 32'd3; sgn32 = 1'b1; conv32 = 1'b1; rm32 = 3'd0;
        @(negedge clk);
        a32 = 32'd5;
        @(negedge clk);
        v32_i = 1'b0;
        n_cmp++;
        if (v32_o !== 1'b1 || rdy32_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got v=%b rdy=%b want v=1 rdy=0", v32_o, rdy32_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (v32_o !== 1'b0 || rdy32_o !== 1'b1 || res32_o !== 32'd0 || fl32_o !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got v=%b rdy=%b res=%h fl=%b want v=0 rdy=1 res=0 fl=0",
                     v32_o, rdy32_o, res32_o, fl32_o);
        end
        rst_n = 1'b1;
        rdy32_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if (v32_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_stale: got valid_o=%b res=%h want valid_o=0", v32_o, res32_o);
            end
        end
        do_op32(32'd3, 1'b1, 1'b1, 3'd0, r, f);
        n_cmp++;
        if (r !== 32'h40400000 || f !== F0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %h/%b want 40400000/00000", r, f);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v32_i = 1'b0; rdy32_i = 1'b1; a32 = '0; sgn32 = 1'b0; conv32 = 1'b0; rm32 = 3'd0;
        v64_i = 1'b0; rdy64_i = 1'b1; a64 = '0; sgn64 = 1'b0; conv64 = 1'b0; rm64 = 3'd0;
        test_reset();
        test_f2i_round();
        test_f2i_sat();
        test_i2f();
        test_xlen64();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
